xpt_sequencer: RTL and testbench
================================

XPT_SEQUENCER -- requirements
Module: xpt_sequencer

Interface
REQ-001 SHALL have port CLK, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-002 SHALL have port RESET, input, 1 bit: synchronous, active-high reset, sampled on the CLK rising edge.
REQ-003 SHALL have port Wait, input, 1 bit: memory wait; 1 = stall all state.
REQ-004 SHALL have port DataIn, input, 8 bits: data bus; sampled as the opcode during fetch.
REQ-005 SHALL have port PR_Reset_XPT, input, 1 bit: decoder request to return XPT to 0.
REQ-006 SHALL have port P2_Set_CM1, input, 1 bit: decoder request to start the next opcode fetch.
REQ-007 SHALL have port P2_Reset_ITABLE, input, 1 bit: decoder request to leave the instruction table.
REQ-008 SHALL have port Pa_Ophd, input, 1 bit: decoder end-of-instruction pulse.
REQ-009 SHALL have port XPT, output, 4 bits: execution phase count.
REQ-010 SHALL have port notXPT, output, 4 bits: bitwise complement of XPT, same cycle.
REQ-011 SHALL have port CM1, output, 1 bit: opcode-fetch machine cycle active.
REQ-012 SHALL have port ITABLE, output, 1 bit: opcode latched, instruction table selected.
REQ-013 SHALL have port OP, output, 8 bits: latched opcode.
REQ-014 SHALL have port DecEnable, output, 1 bit: enable to the instruction decoders.
REQ-015 SHALL have port Retired, output, 8 bits: count of retired instructions.
REQ-016 SHALL have port Fault, output, 1 bit: sticky sequencing error.

Function
REQ-017 "Advance" SHALL be defined as Wait=0 and RESET=0 at a CLK edge; when Wait=1, all registers SHALL hold and all inputs SHALL be ignored.
REQ-018 On advance with qualified PR_Reset_XPT=1, XPT SHALL load 0.
REQ-019 On advance otherwise: XPT<15 SHALL increment XPT by 1; XPT=15 SHALL hold 15 (saturate, no wrap) and SHALL set Fault.
REQ-020 Decoder inputs (REQ-005..008) SHALL be qualified by ITABLE=1; when ITABLE=0 they SHALL be ignored.
REQ-021 Fetch phases SHALL be XPT 0..2 with CM1=1. On advance with CM1=1 and XPT=2: OP SHALL load DataIn, ITABLE SHALL become 1, CM1 SHALL become 0, XPT SHALL become 3.
REQ-022 A qualified P2_Set_CM1 on advance SHALL set CM1=1 at the next edge; when it coincides with the fetch clear of REQ-021, set SHALL win.
REQ-023 A qualified P2_Reset_ITABLE on advance SHALL clear ITABLE at the next edge; when it coincides with the fetch set, the clear SHALL win.
REQ-024 A qualified Pa_Ophd on advance SHALL increment Retired modulo 256 (0xFF -> 0x00).
REQ-025 A qualified Pa_Ophd without a qualified PR_Reset_XPT in the same cycle SHALL set Fault.
REQ-026 Fault, once set, SHALL remain 1 until RESET; sequencing SHALL otherwise continue unchanged.
REQ-027 DecEnable SHALL be combinational: ITABLE & ~Wait & ~Fault.
REQ-028 notXPT SHALL be combinational ~XPT; no other output is combinational.
REQ-029 OP SHALL change only at the fetch edge of REQ-021.
REQ-030 Latency: decoder requests SHALL take effect at the first advancing edge after assertion; there is no further pipelining.

Reset
REQ-031 RESET=1 at an edge SHALL force XPT=0, CM1=1, ITABLE=0, OP=0x00, Retired=0x00, Fault=0, overriding Wait and all other inputs, including mid-instruction.
REQ-032 In the cycle following reset: notXPT=0xF and DecEnable=0.

Verification
REQ-033 LD (HL),nn: reset, then DataIn=0x36 while XPT=2. Required: XPT runs 0,1,2,3,4,5; OP=0x36 and ITABLE=1 from XPT=3; decoder pulses at XPT=5 give XPT=0, CM1=1, ITABLE=0, Retired=1 at the next edge.
REQ-034 Wait=1 for 3 cycles at XPT=4 with ITABLE=1. Required: XPT holds at 4 and DecEnable=0 during the wait; XPT=5 one edge after Wait falls.
REQ-035 No PR_Reset_XPT after fetch. Required: XPT reaches 15 and holds; Fault=1 the following edge; Fault stays 1 until RESET.
REQ-036 Pa_Ophd=1 with PR_Reset_XPT=0 at XPT=4. Required: Retired increments and Fault=1. Separately, Pa_Ophd with ITABLE=0 leaves Retired unchanged.
REQ-037 Retired=0xFF plus one retire. Required: Retired=0x00.
REQ-038 RESET asserted at XPT=4 with Wait=1. Required: next edge gives XPT=0, CM1=1, ITABLE=0, OP=0x00, Fault=0.

Source files
------------

// File: rtl/xpt_sequencer.sv
// Execution-phase sequencer: counts XPT phases, runs the three-phase opcode
// fetch (CM1), latches the opcode into OP and selects the instruction table
// (ITABLE). Decoder requests are honoured only while ITABLE is set.
// Wait=1 freezes every register; RESET has priority over everything.
module xpt_sequencer (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       Wait,
    input  logic [7:0] DataIn,
    input  logic       PR_Reset_XPT,
    input  logic       P2_Set_CM1,
    input  logic       P2_Reset_ITABLE,
    input  logic       Pa_Ophd,
    output logic [3:0] XPT,
    output logic [3:0] notXPT,
    output logic       CM1,
    output logic       ITABLE,
    output logic [7:0] OP,
    output logic       DecEnable,
    output logic [7:0] Retired,
    output logic       Fault
);

    localparam logic [3:0] XPT_MAX       = 4'hF;
    localparam logic [3:0] XPT_FETCH_END = 4'd2;

    logic [3:0] xpt_q,     xpt_d;
    logic       cm1_q,     cm1_d;
    logic       itable_q,  itable_d;
    logic [7:0] op_q,      op_d;
    logic [7:0] retired_q, retired_d;
    logic       fault_q,   fault_d;

    // Decoder requests only count once the instruction table is selected.
    logic q_reset_xpt;
    logic q_set_cm1;
    logic q_reset_itable;
    logic q_ophd;
    logic fetch_edge;

    assign q_reset_xpt    = itable_q & PR_Reset_XPT;
    assign q_set_cm1      = itable_q & P2_Set_CM1;
    assign q_reset_itable = itable_q & P2_Reset_ITABLE;
    assign q_ophd         = itable_q & Pa_Ophd;
    assign fetch_edge     = cm1_q & (xpt_q == XPT_FETCH_END);

    // Next-state logic: hold by default, update only on an advancing edge.
    always_comb begin
        xpt_d     = xpt_q;
        cm1_d     = cm1_q;
        itable_d  = itable_q;
        op_d      = op_q;
        retired_d = retired_q;
        fault_d   = fault_q;

        if (!Wait) begin
            // Phase counter: decoder return-to-zero beats increment; saturate at 15.
            if (q_reset_xpt) begin
                xpt_d = 4'd0;
            end else if (xpt_q != XPT_MAX) begin
                xpt_d = xpt_q + 4'd1;
            end

            // End of fetch: latch opcode, leave CM1, enter the instruction table.
            if (fetch_edge) begin
                op_d     = DataIn;
                itable_d = 1'b1;
                cm1_d    = 1'b0;
            end

            // Decoder requests are applied after the fetch update so they win.
            if (q_set_cm1) begin
                cm1_d = 1'b1;
            end
            if (q_reset_itable) begin
                itable_d = 1'b0;
            end

            if (q_ophd) begin
                retired_d = retired_q + 8'd1;
            end

            // Sticky fault: running off the end of XPT, or ending an
            // instruction without returning XPT to zero.
            if (!q_reset_xpt && ((xpt_q == XPT_MAX) || q_ophd)) begin
                fault_d = 1'b1;
            end
        end
    end

    // State register with synchronous reset overriding Wait.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            xpt_q     <= 4'd0;
            cm1_q     <= 1'b1;
            itable_q  <= 1'b0;
            op_q      <= 8'h00;
            retired_q <= 8'h00;
            fault_q   <= 1'b0;
        end else begin
            xpt_q     <= xpt_d;
            cm1_q     <= cm1_d;
            itable_q  <= itable_d;
            op_q      <= op_d;
            retired_q <= retired_d;
            fault_q   <= fault_d;
        end
    end

    assign XPT       = xpt_q;
    assign notXPT    = ~xpt_q;
    assign CM1       = cm1_q;
    assign ITABLE    = itable_q;
    assign OP        = op_q;
    assign Retired   = retired_q;
    assign Fault     = fault_q;
    assign DecEnable = itable_q & ~Wait & ~fault_q;

endmodule

// File: tb/tb_xpt_sequencer.sv
// Bench for xpt_sequencer: directed scenarios plus a random run, all checked
// against a behavioural model of the sequencing rules.
module tb_xpt_sequencer;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic       Wait = 1'b0;
    logic [7:0] DataIn = 8'h00;
    logic       PR_Reset_XPT = 1'b0;
    logic       P2_Set_CM1 = 1'b0;
    logic       P2_Reset_ITABLE = 1'b0;
    logic       Pa_Ophd = 1'b0;
    logic [3:0] XPT;
    logic [3:0] notXPT;
    logic       CM1;
    logic       ITABLE;
    logic [7:0] OP;
    logic       DecEnable;
    logic [7:0] Retired;
    logic       Fault;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state.
    int       m_xpt;
    bit       m_cm1;
    bit       m_itable;
    bit [7:0] m_op;
    int       m_retired;
    bit       m_fault;

    xpt_sequencer dut (
        .CLK(CLK),
        .RESET(RESET),
        .Wait(Wait),
        .DataIn(DataIn),
        .PR_Reset_XPT(PR_Reset_XPT),
        .P2_Set_CM1(P2_Set_CM1),
        .P2_Reset_ITABLE(P2_Reset_ITABLE),
        .Pa_Ophd(Pa_Ophd),
        .XPT(XPT),
        .notXPT(notXPT),
        .CM1(CM1),
        .ITABLE(ITABLE),
        .OP(OP),
        .DecEnable(DecEnable),
        .Retired(Retired),
        .Fault(Fault)
    );

    // Clock: 10 time-unit period.
    always #5 CLK = ~CLK;

    logic [27:0] act_vec;
    assign act_vec = {XPT, notXPT, CM1, ITABLE, OP, DecEnable, Retired, Fault};

    function automatic logic [27:0] exp_vec();
        logic [3:0] x;
        logic [7:0] r;
        x = 4'(m_xpt);
        r = 8'(m_retired);
        return {x, ~x, m_cm1, m_itable, m_op,
                m_itable & ~Wait & ~m_fault, r, m_fault};
    endfunction

    // Apply one edge of the sequencing rules to the model, using current inputs.
    task automatic model_step();
        if (RESET) begin
            m_xpt = 0; m_cm1 = 1; m_itable = 0; m_op = 8'h00;
            m_retired = 0; m_fault = 0;
        end else if (!Wait) begin
            bit pr, set_cm1, clr_it, ophd, fetch;
            pr      = m_itable && PR_Reset_XPT;
            set_cm1 = m_itable && P2_Set_CM1;
            clr_it  = m_itable && P2_Reset_ITABLE;
            ophd    = m_itable && Pa_Ophd;
            fetch   = m_cm1 && (m_xpt == 2);
            if (!pr && (ophd || m_xpt == 15)) m_fault = 1;
            if (fetch) m_op = DataIn;
            if (pr) m_xpt = 0;
            else if (m_xpt < 15) m_xpt = m_xpt + 1;
            if (set_cm1) m_cm1 = 1;
            else if (fetch) m_cm1 = 0;
            if (clr_it) m_itable = 0;
            else if (fetch) m_itable = 1;
            if (ophd) m_retired = (m_retired + 1) % 256;
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        model_step();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_idle();
        RESET = 0; Wait = 0;
        PR_Reset_XPT = 0; P2_Set_CM1 = 0; P2_Reset_ITABLE = 0; Pa_Ophd = 0;
        DataIn = 8'($urandom);
    endtask

    task automatic set_decode(input bit v);
        PR_Reset_XPT = v; P2_Set_CM1 = v; P2_Reset_ITABLE = v; Pa_Ophd = v;
    endtask

    task automatic do_reset();
        RESET = 1; Wait = 0;
        tick();
        set_idle();
    endtask

    task automatic go_to_xpt(input int n);
        set_idle();
        for (int k = 0; k < 20 && m_xpt != n; k++) begin
            DataIn = 8'($urandom);
            tick();
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            RESET = 1; Wait = 1'($urandom);
            DataIn = 8'($urandom);
            PR_Reset_XPT = 1'($urandom); P2_Set_CM1 = 1'($urandom);
            P2_Reset_ITABLE = 1'($urandom); Pa_Ophd = 1'($urandom);
            tick();
            vectors++;
            if (act_vec !== exp_vec()) begin
                miscompares++;
                $display("FAIL reset_state: got %h expected %h", act_vec, exp_vec());
            end
            vectors++;
            if (XPT !== 4'h0 || notXPT !== 4'hF || DecEnable !== 1'b0 || CM1 !== 1'b1) begin
                miscompares++;
                $display("FAIL reset_outputs: got xpt=%h nxpt=%h de=%b cm1=%b expected 0 f 0 1",
                         XPT, notXPT, DecEnable, CM1);
            end
        end
        set_idle();
    endtask

    task automatic test_ld_hl_nn();
        do_reset();
        for (int p = 0; p <= 5; p++) begin
            vectors++;
            if (XPT !== 4'(p)) begin
                miscompares++;
                $display("FAIL ld_xpt_seq: got %0d expected %0d", XPT, p);
            end
            if (p >= 3) begin
                vectors++;
                if (OP !== 8'h36 || ITABLE !== 1'b1 || CM1 !== 1'b0) begin
                    miscompares++;
                    $display("FAIL ld_opcode: got op=%h it=%b cm1=%b expected 36 1 0", OP, ITABLE, CM1);
                end
            end
            if (p < 5) begin
                DataIn = (p == 2) ? 8'h36 : 8'($urandom);
                tick();
                vectors++;
                if (act_vec !== exp_vec()) begin
                    miscompares++;
                    $display("FAIL ld_vec: got %h expected %h", act_vec, exp_vec());
                end
            end
        end
        set_decode(1);
        tick();
        vectors++;
        if (XPT !== 4'd0 || CM1 !== 1'b1 || ITABLE !== 1'b0 || Retired !== 8'd1 || Fault !== 1'b0) begin
            miscompares++;
            $display("FAIL ld_end: got xpt=%0d cm1=%b it=%b ret=%0d flt=%b expected 0 1 0 1 0",
                     XPT, CM1, ITABLE, Retired, Fault);
        end
        set_idle();
    endtask

    task automatic test_wait();
        do_reset();
        go_to_xpt(4);
        Wait = 1;
        set_decode(1);
        for (int i = 0; i < 3; i++) begin
            DataIn = 8'($urandom);
            tick();
            vectors++;
            if (XPT !== 4'd4 || DecEnable !== 1'b0 || act_vec !== exp_vec()) begin
                miscompares++;
                $display("FAIL wait_hold: got xpt=%0d de=%b vec=%h expected 4 0 %h",
                         XPT, DecEnable, act_vec, exp_vec());
            end
        end
        set_idle();
        tick();
        vectors++;
        if (XPT !== 4'd5 || DecEnable !== 1'b1) begin
            miscompares++;
            $display("FAIL wait_release: got xpt=%0d de=%b expected 5 1", XPT, DecEnable);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        go_to_xpt(15);
        vectors++;
        if (XPT !== 4'd15 || Fault !== 1'b0) begin
            miscompares++;
            $display("FAIL sat_reach: got xpt=%0d flt=%b expected 15 0", XPT, Fault);
        end
        for (int i = 0; i < 4; i++) begin
            Wait = (i == 2);
            tick();
            vectors++;
            if (XPT !== 4'd15 || Fault !== 1'b1 || act_vec !== exp_vec()) begin
                miscompares++;
                $display("FAIL sat_hold: got xpt=%0d flt=%b vec=%h expected 15 1 %h",
                         XPT, Fault, act_vec, exp_vec());
            end
        end
        set_idle();
        set_decode(1);
        tick();
        set_idle();
        tick();
        vectors++;
        if (XPT !== 4'd1 || Fault !== 1'b1 || DecEnable !== 1'b0) begin
            miscompares++;
            $display("FAIL sat_sticky: got xpt=%0d flt=%b de=%b expected 1 1 0", XPT, Fault, DecEnable);
        end
        do_reset();
        vectors++;
        if (Fault !== 1'b0) begin
            miscompares++;
            $display("FAIL sat_clear: got flt=%b expected 0", Fault);
        end
    endtask

    task automatic test_ophd_fault();
        do_reset();
        go_to_xpt(4);
        Pa_Ophd = 1;
        tick();
        vectors++;
        if (Retired !== 8'd1 || Fault !== 1'b1 || XPT !== 4'd5) begin
            miscompares++;
            $display("FAIL ophd_fault: got ret=%0d flt=%b xpt=%0d expected 1 1 5", Retired, Fault, XPT);
        end
        set_idle();
        do_reset();
        set_decode(1);
        tick();
        vectors++;
        if (Retired !== 8'd0 || Fault !== 1'b0 || XPT !== 4'd1 || CM1 !== 1'b1) begin
            miscompares++;
            $display("FAIL ophd_unqualified: got ret=%0d flt=%b xpt=%0d cm1=%b expected 0 0 1 1",
                     Retired, Fault, XPT, CM1);
        end
        set_idle();
    endtask

    task automatic test_retire_wrap();
        do_reset();
        for (int i = 0; i < 256; i++) begin
            go_to_xpt(3);
            set_decode(1);
            tick();
            set_idle();
            vectors++;
            if (act_vec !== exp_vec()) begin
                miscompares++;
                $display("FAIL wrap_vec: got %h expected %h", act_vec, exp_vec());
            end
            if (i == 254) begin
                vectors++;
                if (Retired !== 8'hFF) begin
                    miscompares++;
                    $display("FAIL wrap_ff: got %h expected ff", Retired);
                end
            end
        end
        vectors++;
        if (Retired !== 8'h00 || Fault !== 1'b0) begin
            miscompares++;
            $display("FAIL wrap_zero: got ret=%h flt=%b expected 00 0", Retired, Fault);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_idle();
        for (int k = 0; k < 4; k++) begin
            DataIn = 8'hA5;
            tick();
        end
        Pa_Ophd = 1;
        tick();
        Pa_Ophd = 0;
        Wait = 1;
        RESET = 1;
        set_decode(1);
        tick();
        vectors++;
        if (XPT !== 4'd0 || CM1 !== 1'b1 || ITABLE !== 1'b0 || OP !== 8'h00 ||
            Fault !== 1'b0 || Retired !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_mid: got xpt=%0d cm1=%b it=%b op=%h flt=%b ret=%h expected 0 1 0 00 0 00",
                     XPT, CM1, ITABLE, OP, Fault, Retired);
        end
        set_idle();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            RESET  = ($urandom_range(0, 99) == 0);
            Wait   = ($urandom_range(0, 3) == 0);
            DataIn = 8'($urandom);
            if ($urandom_range(0, 4) == 0) begin
                set_decode(1);
            end else begin
                PR_Reset_XPT    = ($urandom_range(0, 5) == 0);
                P2_Set_CM1      = ($urandom_range(0, 5) == 0);
                P2_Reset_ITABLE = ($urandom_range(0, 5) == 0);
                Pa_Ophd         = ($urandom_range(0, 7) == 0);
            end
            tick();
            vectors++;
            if (act_vec !== exp_vec()) begin
                miscompares++;
                $display("FAIL random_%0d: got %h expected %h", i, act_vec, exp_vec());
            end
        end
        set_idle();
    endtask

    initial begin
        test_reset();
        test_ld_hl_nn();
        test_wait();
        test_saturate();
        test_ophd_fault();
        test_retire_wrap();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
